ahblite_decoder_mux: RTL

AHBLITE_DECODER_MUX -- requirements
Module: ahblite_decoder_mux

---
 rtl/ahblite_pkg.sv | 30 +++
 rtl/ahblite_default_slave.sv | 74 +++++++
 rtl/ahblite_decoder_mux.sv | 86 ++++++++
 3 files changed

// File: rtl/ahblite_pkg.sv
// ahblite_pkg
//   Shared definitions for the AHB-Lite decoder/mux slice: slave count,
//   default region nibbles, data-phase select encoding and the default-slave
//   state encoding.
package ahblite_pkg;

  localparam int NUM_SLAVES = 4;

  // Default HADDR[31:28] match values: code RAM, data RAM, peripherals, spare.
  localparam logic [3:0] S0_NIB_DEF = 4'h0;
  localparam logic [3:0] S1_NIB_DEF = 4'h2;
  localparam logic [3:0] S2_NIB_DEF = 4'h4;
  localparam logic [3:0] S3_NIB_DEF = 4'h5;

  // Low two bits of SEL_S0..SEL_S3 double as the slave index.
  typedef enum logic [2:0] {
    SEL_S0  = 3'd0,
    SEL_S1  = 3'd1,
    SEL_S2  = 3'd2,
    SEL_S3  = 3'd3,
    SEL_DEF = 3'd4
  } sel_t;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave
//   Answers transfers to unmapped addresses. IDLE/BUSY complete as a
//   zero-wait OKAY; NONSEQ/SEQ get the two-cycle AHB ERROR response.
//
//   HCLK, HRESETn   clock, async active-low reset
//   HSEL            address-phase decode selected the default region
//   HTRANS          master transfer type
//   HREADY          bus-wide ready (address phase accepted when high)
//   HREADYOUT       ready driven while the default slave owns the data phase
//   HRESP           response driven while the default slave owns the data phase
//
//   state   | meaning
//   DS_OK   | idle / OKAY, HREADYOUT=1 HRESP=0
//   DS_ERR1 | first ERROR cycle, HREADYOUT=0 HRESP=1
//   DS_ERR2 | second ERROR cycle, HREADYOUT=1 HRESP=1
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_t state;

  // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY.
  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= DS_OK;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      case (state)
        DS_OK: begin
          if (HREADY && HSEL && HTRANS[1]) begin
            state     <= DS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        DS_ERR2: begin
          // HREADY is high here, so the next address phase is always taken.
          if (HSEL && HTRANS[1]) begin
            state     <= DS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            state     <= DS_OK;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        default: begin
          state     <= DS_OK;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahblite_decoder_mux.sv
// ahblite_decoder_mux
//   Single-master AHB-Lite address decoder and slave response multiplexer
//   for four slaves plus an internal default slave.
//
//   HCLK, HRESETn   clock, async active-low reset
//   HADDR, HTRANS   master address phase
//   HSEL_S          one-hot slave select (combinational on HADDR[31:28])
//   HREADYOUT_S     per-slave ready
//   HRESP_S         per-slave response
//   HRDATA_S        per-slave read data, slave n on [32n+31:32n]
//   HREADY          muxed ready to master and all slaves
//   HRESP, HRDATA   muxed response and read data to master
module ahblite_decoder_mux
  import ahblite_pkg::*;
#(
  parameter logic [3:0] S0_NIB = S0_NIB_DEF,
  parameter logic [3:0] S1_NIB = S1_NIB_DEF,
  parameter logic [3:0] S2_NIB = S2_NIB_DEF,
  parameter logic [3:0] S3_NIB = S3_NIB_DEF
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic [NUM_SLAVES-1:0]    HSEL_S,
  input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]    HRESP_S,
  input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [31:0]              HRDATA
);

  sel_t       dec_sel;
  sel_t       sel_q;
  logic [1:0] sel_idx;
  logic       ds_hreadyout;
  logic       ds_hresp;

  // Regions are 256 MB, so only the top nibble takes part in decode.
  logic unused_haddr;
  assign unused_haddr = ^HADDR[27:0];

  // Priority chain: with duplicate nibbles the lowest index wins.
  always_comb begin
    dec_sel = SEL_DEF;
    if      (HADDR[31:28] == S0_NIB) dec_sel = SEL_S0;
    else if (HADDR[31:28] == S1_NIB) dec_sel = SEL_S1;
    else if (HADDR[31:28] == S2_NIB) dec_sel = SEL_S2;
    else if (HADDR[31:28] == S3_NIB) dec_sel = SEL_S3;
  end

  always_comb begin
    HSEL_S = '0;
    if (dec_sel != SEL_DEF) HSEL_S[dec_sel[1:0]] = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= SEL_DEF;
    else if (HREADY) sel_q <= dec_sel;
  end

  assign sel_idx = sel_q[1:0];

  always_comb begin
    HREADY = ds_hreadyout;
    HRESP  = ds_hresp;
    HRDATA = '0;
    if (sel_q != SEL_DEF) begin
      HREADY = HREADYOUT_S[sel_idx];
      HRESP  = HRESP_S[sel_idx];
      HRDATA = HRDATA_S[{sel_idx, 5'b0} +: 32];
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (dec_sel == SEL_DEF),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

endmodule
